// File: rtl/icache_assoc.sv
// Set-associative instruction cache with registered PC, one-cycle read latency, output hold,
// per-set round-robin replacement and a one-set-per-cycle flush sweep.
module icache_assoc #(
    parameter int unsigned icache_tag_width_p  = 12,
    parameter int unsigned icache_addr_width_p = 8,
    parameter int unsigned ways_p              = 2,
    parameter int unsigned instr_width_p       = 32,
    localparam int unsigned pc_width_lp        = icache_tag_width_p + icache_addr_width_p
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           flush_i,
    input  logic                           icache_cen_i,
    input  logic                           icache_w_en_i,
    input  logic [icache_addr_width_p-1:0] icache_w_addr_i,
    input  logic [icache_tag_width_p-1:0]  icache_w_tag_i,
    input  logic [instr_width_p-1:0]       icache_w_instr_i,
    input  logic [pc_width_lp-1:0]         pc_i,
    input  logic                           pc_wen_i,
    output logic [instr_width_p-1:0]       instruction_o,
    output logic [pc_width_lp-1:0]         pc_r_o,
    output logic [pc_width_lp-1:0]         jump_addr_o,
    output logic                           icache_miss_o,
    output logic                           flush_busy_o
);

    localparam int unsigned Sets = 2 ** icache_addr_width_p;
    localparam int unsigned WayW = (ways_p > 1) ? $clog2(ways_p) : 1;
    localparam int unsigned OffW = (pc_width_lp > 21) ? pc_width_lp : 21;

    typedef enum logic [0:0] {StIdle, StSweep} state_e;

    state_e                         state_q;
    logic [icache_addr_width_p-1:0] cnt_q;
    logic                           busy_q;

    logic [ways_p-1:0]             valid_q [Sets];
    logic [WayW-1:0]               rr_q    [Sets];
    logic [icache_tag_width_p-1:0] tag_mem   [ways_p][Sets];
    logic [instr_width_p-1:0]      instr_mem [ways_p][Sets];

    logic [icache_tag_width_p-1:0] rd_tag_q     [ways_p];
    logic [instr_width_p-1:0]      rd_instr_q   [ways_p];
    logic [ways_p-1:0]             rd_valid_q;
    logic [icache_tag_width_p-1:0] hold_tag_q   [ways_p];
    logic [instr_width_p-1:0]      hold_instr_q [ways_p];
    logic [ways_p-1:0]             hold_valid_q;

    logic [pc_width_lp-1:0] pc_r_q;
    logic                   pc_wen_r_q;

    logic                           flushing, wr_en, rd_en;
    logic [icache_addr_width_p-1:0] rd_set;
    logic [WayW-1:0]                victim, rr_inc;
    logic                           use_rr;

    // A pending or running flush blocks both refills and reads.
    assign flushing = flush_i | busy_q;
    assign wr_en    = icache_cen_i & icache_w_en_i & ~flushing;
    assign rd_en    = icache_cen_i & ~icache_w_en_i & ~flushing;
    assign rd_set   = pc_i[icache_addr_width_p-1:0];

    always_comb begin
        victim = rr_q[icache_w_addr_i];
        use_rr = 1'b1;
        for (int unsigned k = 0; k < ways_p; k++) begin
            if (use_rr && !valid_q[icache_w_addr_i][k]) begin
                victim = WayW'(k);
                use_rr = 1'b0;
            end
        end
        rr_inc = (rr_q[icache_w_addr_i] == WayW'(ways_p - 1)) ? '0
                                                              : rr_q[icache_w_addr_i] + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int unsigned s = 0; s < Sets; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            if (wr_en) begin
                valid_q[icache_w_addr_i][victim] <= 1'b1;
                if (use_rr) rr_q[icache_w_addr_i] <= rr_inc;
            end
            unique case (state_q)
                StIdle: begin
                    if (flush_i) begin
                        state_q <= StSweep;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StSweep: begin
                    valid_q[cnt_q] <= '0;
                    if (flush_i) begin
                        cnt_q <= '0;
                    end else if (cnt_q == '1) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            tag_mem[victim][icache_w_addr_i]   <= icache_w_tag_i;
            instr_mem[victim][icache_w_addr_i] <= icache_w_instr_i;
        end
        if (rd_en) begin
            for (int unsigned k = 0; k < ways_p; k++) begin
                rd_tag_q[k]   <= tag_mem[k][rd_set];
                rd_instr_q[k] <= instr_mem[k][rd_set];
            end
        end
    end

    logic [icache_tag_width_p-1:0] b_tag   [ways_p];
    logic [instr_width_p-1:0]      b_instr [ways_p];
    logic [ways_p-1:0]             b_valid;

    always_comb begin
        b_valid = pc_wen_r_q ? rd_valid_q : hold_valid_q;
        for (int unsigned k = 0; k < ways_p; k++) begin
            b_tag[k]   = pc_wen_r_q ? rd_tag_q[k]   : hold_tag_q[k];
            b_instr[k] = pc_wen_r_q ? rd_instr_q[k] : hold_instr_q[k];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i || flush_i) begin
            rd_valid_q   <= '0;
            hold_valid_q <= '0;
            for (int unsigned k = 0; k < ways_p; k++) begin
                hold_tag_q[k]   <= '0;
                hold_instr_q[k] <= '0;
            end
        end else begin
            if (rd_en) rd_valid_q <= valid_q[rd_set];
            hold_valid_q <= b_valid;
            for (int unsigned k = 0; k < ways_p; k++) begin
                hold_tag_q[k]   <= b_tag[k];
                hold_instr_q[k] <= b_instr[k];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            pc_r_q     <= '0;
            pc_wen_r_q <= 1'b0;
        end else begin
            if (pc_wen_i) pc_r_q <= pc_i;
            pc_wen_r_q <= pc_wen_i;
        end
    end

    logic [icache_tag_width_p-1:0] pc_tag;
    logic                          hit_any;
    logic [instr_width_p-1:0]      sel_instr;

    assign pc_tag = pc_r_q[pc_width_lp-1 -: icache_tag_width_p];

    // Lowest-index hit wins; on a miss way 0 data passes through.
    always_comb begin
        hit_any   = 1'b0;
        sel_instr = b_instr[0];
        for (int unsigned k = 0; k < ways_p; k++) begin
            if (!hit_any && b_valid[k] && (b_tag[k] == pc_tag)) begin
                hit_any   = 1'b1;
                sel_instr = b_instr[k];
            end
        end
    end

    assign instruction_o = sel_instr;
    assign icache_miss_o = ~hit_any | busy_q;
    assign flush_busy_o  = busy_q;
    assign pc_r_o        = pc_r_q;

    logic [31:0]            ins;
    logic signed [20:0]     j_imm;
    logic signed [12:0]     b_imm;
    logic signed [OffW-1:0] off, off_w;

    assign ins   = instruction_o[31:0];
    assign j_imm = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    assign b_imm = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign off   = (ins[6:0] == 7'b1101111) ? OffW'(j_imm) : OffW'(b_imm);
    assign off_w = off >>> 2;

    // Word-address target; overflow wraps silently.
    assign jump_addr_o = pc_r_q + off_w[pc_width_lp-1:0];

endmodule

// File: tb/tb_icache_assoc.sv
// Self-checking bench for icache_assoc: fetch results are queued as expectations when a fetch
// is driven and compared one cycle later when the cache presents them.
module tb_icache_assoc;

    logic        clk = 1'b0;
    logic        reset_n, flush, cen, w_en, pc_wen;
    logic [7:0]  w_addr;
    logic [11:0] w_tag;
    logic [31:0] w_instr;
    logic [19:0] pc;
    logic [31:0] instruction;
    logic [19:0] pc_r, jump_addr;
    logic        miss, busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       nm;
        logic        miss;
        bit          chk_instr;
        logic [31:0] instr;
        bit          chk_jump;
        logic [19:0] jump;
    } exp_t;

    exp_t sb[$];

    icache_assoc dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .flush_i          (flush),
        .icache_cen_i     (cen),
        .icache_w_en_i    (w_en),
        .icache_w_addr_i  (w_addr),
        .icache_w_tag_i   (w_tag),
        .icache_w_instr_i (w_instr),
        .pc_i             (pc),
        .pc_wen_i         (pc_wen),
        .instruction_o    (instruction),
        .pc_r_o           (pc_r),
        .jump_addr_o      (jump_addr),
        .icache_miss_o    (miss),
        .flush_busy_o     (busy)
    );

    always #5 clk = ~clk;

    // The fetch unit must never refill while a sweep is running.
    always @(posedge clk) begin
        if (reset_n && busy && cen && w_en) begin
            errors++;
            $display("FAIL refill_while_busy: refill issued with flush_busy_o=1");
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic refill(input logic [7:0] s, input logic [11:0] t, input logic [31:0] d);
        cen = 1'b1; w_en = 1'b1; pc_wen = 1'b0;
        w_addr = s; w_tag = t; w_instr = d;
        tick();
        cen = 1'b0; w_en = 1'b0;
    endtask

    task automatic drive_fetch(input string nm, input logic [19:0] p, input logic m,
                               input bit ci, input logic [31:0] d,
                               input bit cj, input logic [19:0] j);
        exp_t e;
        cen = 1'b1; w_en = 1'b0; pc_wen = 1'b1; pc = p;
        e.nm = nm; e.miss = m; e.chk_instr = ci; e.instr = d; e.chk_jump = cj; e.jump = j;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] enc_jal(input int imm);
        logic [20:0] b;
        b = imm[20:0];
        return {b[20], b[10:1], b[11], b[19:12], 5'd0, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_beq(input int imm);
        logic [12:0] b;
        b = imm[12:0];
        return {b[12], b[10:5], 5'd0, 5'd0, 3'b000, b[4:1], b[11], 7'b1100011};
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; pc_wen = 1'b0; cen = 1'b0; w_en = 1'b0; flush = 1'b0;
        tick();
        checks++;
        if (miss !== 1'b1) begin errors++; $display("FAIL reset_miss: got %b want 1", miss); end
        checks++;
        if (instruction !== 32'h0) begin
            errors++; $display("FAIL reset_instr: got %h want 0", instruction);
        end
        checks++;
        if (pc_r !== 20'h0) begin errors++; $display("FAIL reset_pc_r: got %h want 0", pc_r); end
        checks++;
        if (jump_addr !== 20'h0) begin
            errors++; $display("FAIL reset_jump: got %h want 0", jump_addr);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset_n = 1'b1;
        drive_fetch("cold_read", 20'h00010, 1'b1, 1'b0, 32'h0, 1'b0, 20'h0);
        tick();
        pc_wen = 1'b0;
        begin
            exp_t e = sb.pop_front();
            checks++;
            if (miss !== e.miss) begin
                errors++; $display("FAIL %s miss: got %b want %b", e.nm, miss, e.miss);
            end
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL cold_busy: got %b want 0", busy); end
        end
    endtask

    task automatic test_refill_hold();
        refill(8'h10, 12'hABC, 32'h00000013);
        drive_fetch("refill_hit", 20'hABC10, 1'b0, 1'b1, 32'h00000013, 1'b0, 20'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            exp_t e = sb.pop_front();
            checks++;
            if (miss !== e.miss) begin
                errors++; $display("FAIL %s miss: got %b want %b", e.nm, miss, e.miss);
            end
            checks++;
            if (instruction !== e.instr) begin
                errors++; $display("FAIL %s instr: got %h want %h", e.nm, instruction, e.instr);
            end
            checks++;
            if (pc_r !== 20'hABC10) begin
                errors++; $display("FAIL %s pc_r: got %h want abc10", e.nm, pc_r);
            end
            if (i == 3) break;
            // Keep reading a different set with pc_wen low; the output must not move.
            pc_wen = 1'b0; cen = 1'b1; w_en = 1'b0; pc = 20'h12345 + 20'(i);
            sb.push_back('{nm: "hold", miss: 1'b0, chk_instr: 1'b1, instr: 32'h00000013,
                           chk_jump: 1'b0, jump: 20'h0});
            tick();
        end
        cen = 1'b0;
    endtask

    task automatic test_replacement();
        for (int t = 1; t <= 3; t++) refill(8'h05, 12'(t), 32'h100 + 32'(t));
        drive_fetch("evicted_tag1", {12'd1, 8'h05}, 1'b1, 1'b0, 32'h0, 1'b0, 20'h0);
        tick();
        drive_fetch("kept_tag2", {12'd2, 8'h05}, 1'b0, 1'b1, 32'h102, 1'b0, 20'h0);
        for (int i = 0; i < 3; i++) begin
            exp_t e = sb.pop_front();
            checks++;
            if (miss !== e.miss) begin
                errors++; $display("FAIL %s miss: got %b want %b", e.nm, miss, e.miss);
            end
            if (e.chk_instr) begin
                checks++;
                if (instruction !== e.instr) begin
                    errors++;
                    $display("FAIL %s instr: got %h want %h", e.nm, instruction, e.instr);
                end
            end
            tick();
            if (i == 0) drive_fetch("new_tag3", {12'd3, 8'h05}, 1'b0, 1'b1, 32'h103, 1'b0, 0);
        end
        pc_wen = 1'b0; cen = 1'b0;
    endtask

    task automatic test_jump();
        int jal_imm = -8;
        int beq_imm = 4092;
        logic [19:0] jal_pc = 20'h00001;
        logic [19:0] beq_pc = 20'h00100;
        refill(8'h01, 12'h000, enc_jal(jal_imm));
        refill(8'h00, 12'h001, enc_beq(beq_imm));
        drive_fetch("jal_wrap", jal_pc, 1'b0, 1'b1, enc_jal(jal_imm), 1'b1,
                    20'(int'(jal_pc) + jal_imm / 4));
        tick();
        drive_fetch("beq_fwd", beq_pc, 1'b0, 1'b1, enc_beq(beq_imm), 1'b1,
                    20'(int'(beq_pc) + beq_imm / 4));
        for (int i = 0; i < 2; i++) begin
            exp_t e = sb.pop_front();
            checks++;
            if (miss !== e.miss) begin
                errors++; $display("FAIL %s miss: got %b want %b", e.nm, miss, e.miss);
            end
            checks++;
            if (instruction !== e.instr) begin
                errors++; $display("FAIL %s instr: got %h want %h", e.nm, instruction, e.instr);
            end
            checks++;
            if (jump_addr !== e.jump) begin
                errors++; $display("FAIL %s jump: got %h want %h", e.nm, jump_addr, e.jump);
            end
            if (i == 0) tick();
        end
        tick();
        pc_wen = 1'b0; cen = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [19:0] pcs [4]   = '{20'hABC10, {12'd2, 8'h05}, {12'd1, 8'h05}, {12'd3, 8'h05}};
        logic        ms  [4]   = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] ds  [4]   = '{32'h13, 32'h102, 32'h0, 32'h103};
        drive_fetch("b2b_0", pcs[0], ms[0], !ms[0], ds[0], 1'b0, 20'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i < 3) drive_fetch($sformatf("b2b_%0d", i + 1), pcs[i+1], ms[i+1], !ms[i+1],
                                   ds[i+1], 1'b0, 20'h0);
            else pc_wen = 1'b0;
            begin
                exp_t e = sb.pop_front();
                checks++;
                if (miss !== e.miss) begin
                    errors++; $display("FAIL %s miss: got %b want %b", e.nm, miss, e.miss);
                end
                if (e.chk_instr) begin
                    checks++;
                    if (instruction !== e.instr) begin
                        errors++;
                        $display("FAIL %s instr: got %h want %h", e.nm, instruction, e.instr);
                    end
                end
            end
        end
        cen = 1'b0;
    endtask

    task automatic test_flush();
        int n = 0;
        int miss_bad = 0;
        logic [19:0] pcs [4] = '{20'hABC10, {12'd2, 8'h05}, {12'd3, 8'h05}, 20'h00001};
        flush = 1'b1;
        tick();
        flush = 1'b0;
        while (busy && n < 1000) begin
            n++;
            if (miss !== 1'b1) miss_bad++;
            tick();
        end
        checks++;
        if (n != 256) begin errors++; $display("FAIL flush_len: got %0d cycles want 256", n); end
        checks++;
        if (miss_bad != 0) begin
            errors++; $display("FAIL flush_miss_forced: got %0d hit cycles want 0", miss_bad);
        end
        foreach (pcs[i]) begin
            drive_fetch("post_flush", pcs[i], 1'b1, 1'b0, 32'h0, 1'b0, 20'h0);
            tick();
            begin
                exp_t e = sb.pop_front();
                checks++;
                if (miss !== e.miss) begin
                    errors++;
                    $display("FAIL %s miss @%h: got %b want %b", e.nm, pcs[i], miss, e.miss);
                end
            end
        end
        pc_wen = 1'b0; cen = 1'b0;
    endtask

    task automatic test_flush_restart();
        int n = 0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        while (busy && n < 2000) begin
            n++;
            flush = (n == 100);
            tick();
        end
        flush = 1'b0;
        checks++;
        if (n != 356) begin
            errors++; $display("FAIL flush_restart_len: got %0d cycles want 356", n);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n = 0;
        refill(8'd200, 12'h007, 32'h777);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++;
        if (miss !== 1'b1) begin errors++; $display("FAIL abort_miss: got %b want 1", miss); end
        checks++;
        if (pc_r !== 20'h0) begin errors++; $display("FAIL abort_pc_r: got %h want 0", pc_r); end
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got %b want 0", busy); end
        // Set 200 lies beyond where the sweep stopped, so only reset can have cleared it.
        drive_fetch("unswept_set", {12'h007, 8'd200}, 1'b1, 1'b0, 32'h0, 1'b0, 20'h0);
        tick();
        pc_wen = 1'b0; cen = 1'b0;
        begin
            exp_t e = sb.pop_front();
            checks++;
            if (miss !== e.miss) begin
                errors++; $display("FAIL %s miss: got %b want %b", e.nm, miss, e.miss);
            end
        end
        // Set 5 pointer was 1 before reset; a cleared pointer makes tag 3 evict tag 1.
        for (int t = 1; t <= 3; t++) refill(8'h05, 12'(t), 32'h500 + 32'(t));
        for (int t = 1; t <= 3; t++) begin
            drive_fetch($sformatf("rr_reset_tag%0d", t), {12'(t), 8'h05}, (t == 1), (t != 1),
                        32'h500 + 32'(t), 1'b0, 20'h0);
            tick();
            begin
                exp_t e = sb.pop_front();
                checks++;
                if (miss !== e.miss) begin
                    errors++; $display("FAIL %s miss: got %b want %b", e.nm, miss, e.miss);
                end
                if (e.chk_instr) begin
                    checks++;
                    if (instruction !== e.instr) begin
                        errors++;
                        $display("FAIL %s instr: got %h want %h", e.nm, instruction, e.instr);
                    end
                end
            end
        end
        pc_wen = 1'b0; cen = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; cen = 1'b0; w_en = 1'b0; pc_wen = 1'b0;
        w_addr = '0; w_tag = '0; w_instr = '0; pc = '0;
        tick();
        tick();
        reset_n = 1'b1;
        test_reset();
        test_refill_hold();
        test_replacement();
        test_jump();
        test_back_to_back();
        test_flush();
        test_flush_restart();
        test_reset_mid_sweep();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_assoc.md
Name: icache_assoc

Overview:
- Parametrised set-associative successor to the single-way direct-mapped instruction cache in the vanilla core front end.
- ways_p ways per set, each entry holding {tag, instr}.
- Per-entry valid bits are held in flops. Replacement uses a per-set round-robin pointer.
- A flush sequencer sweeps the valid bits one set per cycle.
- The block keeps the existing fetch contract: registered PC, one-cycle read latency, output hold while the PC is not written, a word-address jump target, and a miss flag.

Parameters:
- icache_tag_width_p, 12, tag bits (upper PC word-address bits).
- icache_addr_width_p, 8, set-index bits; sets = 2**icache_addr_width_p.
- ways_p, 2, associativity, power of two, 1..8.
- instr_width_p, 32, instruction width.
- pc_width_lp, icache_tag_width_p+icache_addr_width_p, PC word-address width (derived).

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  synchronous active-low reset
- flush_i  in  1  one-cycle pulse: invalidate all entries
- icache_cen_i  in  1  array enable (read or write)
- icache_w_en_i  in  1  refill write
- icache_w_addr_i  in  icache_addr_width_p  refill set index
- icache_w_tag_i  in  icache_tag_width_p  refill tag
- icache_w_instr_i  in  instr_width_p  refill instruction
- pc_i  in  pc_width_lp  next fetch PC (word address)
- pc_wen_i  in  1  PC advance
- instruction_o  out  instr_width_p  fetched instruction
- pc_r_o  out  pc_width_lp  registered PC
- jump_addr_o  out  pc_width_lp  branch/JAL target, word address
- icache_miss_o  out  1  no valid way matches pc_r tag
- flush_busy_o  out  1  flush sweep in progress

Behaviour:
- Reset (reset_n_i=0 at an edge):
  - All valid bits, round-robin pointers, pc_r, pc_wen_r and the held output are cleared to 0; the FSM goes to IDLE.
  - Resulting outputs: instruction_o=0, pc_r_o=0, jump_addr_o=0, flush_busy_o=0, icache_miss_o=1.
  - Reset asserted mid-flush aborts the sweep and clears everything.
- Read:
  - When icache_cen_i=1, icache_w_en_i=0 and not flushing, all ways read set pc_i[icache_addr_width_p-1:0].
  - Data is available the next cycle.
  - pc_r <= pc_i when pc_wen_i=1; pc_wen_r <= pc_wen_i.
- Hold:
  - If pc_wen_r=1, the output bundle is the fresh array read plus a snapshot of the set's valid bits; otherwise it is the registered held copy.
  - The held copy updates every cycle from the bundle and is cleared by flush start.
- Hit and miss:
  - way k hits iff valid[k] & tag[k] == pc_r[top icache_tag_width_p bits].
  - On multiple hits the lowest-index way wins; contents are identical by construction.
  - icache_miss_o = ~any hit, and is forced to 1 while flush_busy_o=1.
  - On a miss, instruction_o carries way 0 data and is don't-care.
- Refill write (icache_cen_i & icache_w_en_i, not flushing):
  - Victim is the lowest-index invalid way in the set; if none, the set's round-robin pointer.
  - Write tag and instr, set valid.
  - Increment the pointer mod ways_p only when it was used.
  - A write has priority over a same-cycle read.
- Flush FSM:
  - IDLE --flush_i--> SWEEP, with counter = 0.
  - In SWEEP, valid[counter][*] is cleared and the counter increments each cycle.
  - At counter == sets-1, clear the last set and return to IDLE.
  - flush_busy_o=1 exactly for the sets cycles of SWEEP.
  - flush_i during SWEEP restarts the counter at 0.
  - Writes during SWEEP, or in the same cycle as flush_i, are dropped. The fetch unit must not refill while busy; the bench asserts this.
- Jump target:
  - From the output instruction: JAL uses sext(J-imm, 21 b byte offset); otherwise sext(B-imm, 13 b).
  - jump_addr_o = pc_r + (offset >>> 2), modulo 2**pc_width_lp, so wrap-around is silent.
  - jump_addr_o is combinational from pc_r and instruction_o.

Test Plan:
- Reset, then read pc=0x00010 → icache_miss_o=1, instruction_o=0, flush_busy_o=0.
- Refill set 0x10 tag 0xABC instr 0x00000013, then pc_wen with pc_i={0xABC,0x10} → next cycle miss=0, instruction_o=0x00000013; hold pc_wen=0 for 3 cycles → output unchanged.
- ways_p=2, fill set 5 with tags 1,2,3 → tag 3 evicts way 0 (tag 1); fetch tag 1 misses, tags 2/3 hit.
- Flush after fills (sets=256) → flush_busy_o high exactly 256 cycles, miss forced 1; afterwards all fetches miss. Second flush_i at cycle 100 → busy extends to 356 total.
- JAL imm=-8 bytes at pc=0x00001 → jump_addr_o=0xFFFFF (wrap). BEQ imm=+4092 at pc=0x00100 → 0x004FF.
- Reset_n_i low at sweep cycle 40 → FSM IDLE, busy=0, all invalid, rr pointers 0.
